// File: rtl/saturn_pkg.sv
// rtl/saturn_pkg.sv - shared constants and types for the Saturn nibble fetch unit
package saturn_pkg;

    localparam int NIBBLE_W      = 4;
    localparam int FIELD_NIBBLES = 16;
    localparam int FIELD_W       = NIBBLE_W * FIELD_NIBBLES;
    localparam int ROM_RESET_VEC = 0;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } collect_state_e;

endpackage

// File: rtl/saturn_fetch_unit_if.sv
// rtl/saturn_fetch_unit_if.sv - decoder request/response channel of the fetch unit
interface saturn_fetch_unit_if #(
    parameter int ADDR_W = 20
);
    import saturn_pkg::*;

    logic                  req_valid;
    logic [3:0]            req_len;
    logic                  req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [FIELD_W-1:0]    rsp_data;
    logic [ADDR_W-1:0]     rsp_addr;

    modport master (
        output req_valid, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr
    );

    modport slave (
        input  req_valid, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr
    );

endinterface

// File: rtl/saturn_nibble_fifo.sv
// rtl/saturn_nibble_fifo.sv - DEPTH x 4 prefetch buffer; flush wins over push and pop
module saturn_nibble_fifo
    import saturn_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [NIBBLE_W-1:0]       din,
    output logic [NIBBLE_W-1:0]       dout,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty
);
    localparam int PW = $clog2(DEPTH);

    logic [NIBBLE_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [PW:0]         count_q;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/saturn_fetch_unit.sv
// rtl/saturn_fetch_unit.sv - sequential nibble prefetch plus 1..16 nibble field collector
module saturn_fetch_unit
    import saturn_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [NIBBLE_W-1:0]   mem_data,
    input  logic                  jump_valid,
    input  logic [ADDR_W-1:0]     jump_addr,
    saturn_fetch_unit_if.slave    dec,
    output logic [ADDR_W-1:0]     pc
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(ROM_RESET_VEC);

    logic [ADDR_W-1:0]   fetch_ptr_q, fetch_ptr_d;
    logic [MEM_LAT-1:0]  inflight_q, inflight_d;
    int                  occupancy;

    logic [PW:0]         fifo_count;
    logic                fifo_empty;
    logic [NIBBLE_W-1:0] fifo_dout;
    logic                push;
    logic                pop;

    collect_state_e      state_q;
    logic [3:0]          len_q;
    logic [3:0]          ctr_q;
    logic [FIELD_W-1:0]  field_q;
    logic [ADDR_W-1:0]   rsp_addr_q;
    logic [ADDR_W-1:0]   pc_q;
    logic                rsp_valid_q;

    // In-flight reads count against buffer space, so a return always has room.
    always_comb begin
        occupancy   = 32'(fifo_count) + $countones(inflight_q);
        mem_en      = reset_n && !jump_valid && (occupancy < DEPTH);
        inflight_d  = '0;
        fetch_ptr_d = fetch_ptr_q;
        if (jump_valid) begin
            fetch_ptr_d = jump_addr;
        end else begin
            inflight_d[0] = mem_en;
            for (int i = 1; i < MEM_LAT; i++) begin
                inflight_d[i] = inflight_q[i-1];
            end
            if (mem_en) fetch_ptr_d = fetch_ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_ptr_q <= RST_ADDR;
            inflight_q  <= '0;
        end else begin
            fetch_ptr_q <= fetch_ptr_d;
            inflight_q  <= inflight_d;
        end
    end

    assign push = inflight_q[MEM_LAT-1] && !jump_valid;
    assign pop  = (state_q == COLLECT) && !fifo_empty && !jump_valid;

    saturn_nibble_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (jump_valid),
        .din     (mem_data),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            ctr_q       <= '0;
            field_q     <= '0;
            rsp_addr_q  <= RST_ADDR;
            pc_q        <= RST_ADDR;
            rsp_valid_q <= 1'b0;
        end else if (jump_valid) begin
            state_q     <= IDLE;
            pc_q        <= jump_addr;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dec.req_valid) begin
                        len_q      <= dec.req_len;
                        ctr_q      <= '0;
                        field_q    <= '0;
                        rsp_addr_q <= pc_q;
                        state_q    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (pop) begin
                        field_q[{ctr_q, 2'b00} +: NIBBLE_W] <= fifo_dout;
                        pc_q <= pc_q + ADDR_W'(1);
                        if (ctr_q == len_q) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            ctr_q <= ctr_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (dec.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr      = fetch_ptr_q;
    assign pc            = pc_q;
    assign dec.req_ready = (state_q == IDLE) && !jump_valid;
    assign dec.rsp_valid = rsp_valid_q;
    assign dec.rsp_data  = field_q;
    assign dec.rsp_addr  = rsp_addr_q;

endmodule

// File: tb/tb_saturn_fetch_unit.sv
// tb/tb_saturn_fetch_unit.sv - self-checking bench for saturn_fetch_unit against a ROM/address model
module tb_saturn_fetch_unit;
    import saturn_pkg::*;

    localparam int ADDR_W  = 17;
    localparam int DEPTH   = 4;
    localparam int MEM_LAT = 3;
    localparam int ROM_N   = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_data;
    logic              jump_valid = 1'b0;
    logic [ADDR_W-1:0] jump_addr = '0;
    logic [ADDR_W-1:0] pc;

    saturn_fetch_unit_if #(.ADDR_W(ADDR_W)) dec_if ();

    saturn_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .dec        (dec_if.slave),
        .pc         (pc)
    );

    logic [3:0]        rom [ROM_N];
    logic [ADDR_W-1:0] pipe_a [MEM_LAT];

    always @(posedge clk) begin
        for (int i = MEM_LAT - 1; i > 0; i--) pipe_a[i] <= pipe_a[i-1];
        pipe_a[0] <= mem_addr;
    end
    assign mem_data = rom[pipe_a[MEM_LAT-1]];

    int                checks = 0;
    int                failures = 0;
    logic [ADDR_W-1:0] exp_fetch = '0;
    logic [ADDR_W-1:0] model_pc = '0;
    logic [ADDR_W-1:0] cur_start;
    logic [3:0]        cur_len;
    logic [63:0]       exp_data;
    logic [63:0]       last_data;
    int                lat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: fetch-rule checks at the falling edge, model update at the rising edge.
    task automatic step();
        logic en_s, jv_s, rst_s;
        logic [ADDR_W-1:0] occ, ja_s;
        @(negedge clk);
        en_s = mem_en; jv_s = jump_valid; rst_s = reset_n; ja_s = jump_addr;
        occ = exp_fetch - pc;
        if (!rst_s) begin
            chk("mem_en_in_reset", 64'(en_s), 64'(0));
        end else begin
            chk("mem_en_rule", 64'(en_s), 64'((occ < DEPTH) && !jv_s));
            chk("occupancy_bound", 64'(occ <= DEPTH), 64'(1));
            if (en_s) chk("mem_addr", 64'(mem_addr), 64'(exp_fetch));
        end
        @(posedge clk);
        if (!rst_s)     exp_fetch = '0;
        else if (jv_s)  exp_fetch = ja_s;
        else if (en_s)  exp_fetch = exp_fetch + 1'b1;
        #1;
    endtask

    task automatic accept(input logic [3:0] len);
        int n;
        n = 0;
        dec_if.req_valid = 1'b1;
        dec_if.req_len   = len;
        #1;
        while (!dec_if.req_ready && n < 50) begin step(); n++; end
        chk("req_ready", 64'(dec_if.req_ready), 64'(1));
        cur_start = model_pc;
        cur_len   = len;
        exp_data  = '0;
        for (int i = 0; i <= int'(len); i++) begin
            exp_data[4*i +: 4] = rom[ADDR_W'(int'(cur_start) + i)];
        end
        step();
        dec_if.req_valid = 1'b0;
    endtask

    task automatic finish(input int hold, input logic tied, output int n);
        logic [ADDR_W-1:0] end_pc;
        end_pc = ADDR_W'(int'(cur_start) + int'(cur_len) + 1);
        dec_if.rsp_ready = tied;
        #1;
        n = 0;
        while (!dec_if.rsp_valid && n < 200) begin step(); n++; end
        chk("rsp_valid", 64'(dec_if.rsp_valid), 64'(1));
        for (int h = 0; h < hold; h++) begin
            chk("hold_data", dec_if.rsp_data, exp_data);
            chk("hold_pc", 64'(pc), 64'(end_pc));
            step();
        end
        if (hold >= 5) begin
            chk("fill_occupancy", 64'(exp_fetch - pc), 64'(DEPTH));
            chk("fill_mem_en", 64'(mem_en), 64'(0));
        end
        last_data = dec_if.rsp_data;
        chk("rsp_data", dec_if.rsp_data, exp_data);
        chk("rsp_addr", 64'(dec_if.rsp_addr), 64'(cur_start));
        chk("pc_after", 64'(pc), 64'(end_pc));
        dec_if.rsp_ready = 1'b1;
        step();
        dec_if.rsp_ready = tied;
        chk("rsp_released", 64'(dec_if.rsp_valid), 64'(0));
        model_pc = end_pc;
    endtask

    task automatic do_jump(input logic [ADDR_W-1:0] t);
        jump_addr  = t;
        jump_valid = 1'b1;
        #1;
        chk("req_ready_in_jump", 64'(dec_if.req_ready), 64'(0));
        step();
        jump_valid = 1'b0;
        model_pc   = t;
        chk("pc_after_jump", 64'(pc), 64'(t));
    endtask

    initial begin
        logic [ADDR_W-1:0] a2;
        logic              tied;
        int                n;

        for (int i = 0; i < ROM_N; i++) rom[i] = 4'($urandom);
        rom[0] = 4'h2; rom[1] = 4'h3; rom[2] = 4'h4; rom[3] = 4'h5;
        dec_if.req_valid = 1'b0;
        dec_if.req_len   = '0;
        dec_if.rsp_ready = 1'b0;

        #3;
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_req_ready", 64'(dec_if.req_ready), 64'(1));
        chk("rst_rsp_valid", 64'(dec_if.rsp_valid), 64'(0));
        chk("rst_rsp_data", dec_if.rsp_data, 64'(0));
        chk("rst_rsp_addr", 64'(dec_if.rsp_addr), 64'(0));
        chk("rst_pc", 64'(pc), 64'(0));
        step(); step();
        reset_n = 1'b1;

        accept(4'd3);
        finish(0, 1'b0, lat);
        chk("first_field", last_data, 64'h5432);
        chk("first_pc", 64'(pc), 64'(4));

        accept(4'd2);
        finish(5, 1'b0, lat);

        accept(4'd3);
        finish(0, 1'b0, lat);
        chk("full_buffer_latency", 64'(lat), 64'(4));

        accept(4'd7);
        a2 = cur_start + 2'd2;
        n = 0;
        while (pc !== a2 && n < 50) begin step(); n++; end
        chk("third_pop_cycle", 64'(pc), 64'(a2));
        dec_if.rsp_ready = 1'b1;
        do_jump(ADDR_W'($urandom));
        for (int i = 0; i < 8; i++) begin
            chk("no_rsp_after_jump", 64'(dec_if.rsp_valid), 64'(0));
            step();
        end
        dec_if.rsp_ready = 1'b0;
        accept(4'd5);
        finish(0, 1'b0, lat);

        for (int i = 0; i < 12; i++) begin
            dec_if.rsp_ready = 1'b1;
            accept(4'd0);
            finish(0, 1'b1, lat);
        end
        dec_if.rsp_ready = 1'b0;

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) do_jump(ADDR_W'($urandom));
            tied = 1'($urandom_range(0, 1));
            dec_if.rsp_ready = tied;
            accept(4'($urandom_range(0, 15)));
            finish(tied ? 0 : int'($urandom_range(0, 3)), tied, lat);
        end
        dec_if.rsp_ready = 1'b0;

        accept(4'd15);
        step(); step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_mem_en", 64'(mem_en), 64'(0));
        chk("async_rst_rsp_valid", 64'(dec_if.rsp_valid), 64'(0));
        chk("async_rst_pc", 64'(pc), 64'(0));
        chk("async_rst_rsp_data", dec_if.rsp_data, 64'(0));
        exp_fetch = '0;
        model_pc  = '0;
        step(); step();
        reset_n = 1'b1;
        accept(4'd3);
        finish(0, 1'b0, lat);
        chk("restart_field", last_data, 64'h5432);

        rom[0] = 4'hC; rom[1] = 4'hD; rom[ROM_N-2] = 4'hA; rom[ROM_N-1] = 4'hB;
        do_jump(17'h1FFFE);
        accept(4'd3);
        for (int k = 0; k <= MEM_LAT; k++) begin
            chk("cold_start_no_pop", 64'(pc), 64'(17'h1FFFE));
            step();
        end
        chk("cold_start_first_pop", 64'(pc), 64'(17'h1FFFF));
        finish(0, 1'b0, lat);
        chk("wrap_field", last_data, 64'hDCBA);
        chk("wrap_pc", 64'(pc), 64'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
